sun_feeder: RTL and testbench
=============================

SUN_FEEDER -- requirements
Module: sun_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, pixel FIFO entries (power of two, >=2).
REQ-002 Parameter GAP_CYC, default 4, minimum idle cycles (psels=0) after every pixel-write completion.
REQ-003 Parameter WAIT_MAX, default 15, maximum access-phase cycles before timeout.
REQ-004 pclk  in  1  single clock; all logic on rising edge.
REQ-005 presetn  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle pulse: begin a frame, sampled only in IDLE.
REQ-007 cfg_threshold  in  8; cfg_xmax  in  8 (pixels per frame, 0 means 256); cfg_ymax  in  8; all captured at start.
REQ-008 pix_valid  in  1; pix_data  in  8; pix_ready  out  1: valid/ready pixel stream, transfer when both high.
REQ-009 psels, penables, pwrites  out  1 each; paddrs  out  32; pwdatas  out  32: APB master request.
REQ-010 prdatas  in  32; preadys  in  1: APB completion and read data.
REQ-011 busy  out  1; frame_done  out  1 (one-cycle pulse); err  out  1 (sticky); sum_out  out  32; sum_valid  out  1.

Function
REQ-012 Sequencer states: IDLE, CTRL, THR, XMAX, YMAX, PIX, GAP, RDSUM, DONE; busy=1 in every state except IDLE.
REQ-013 IDLE + start -> CTRL; writes issued in order: addr 0x00 data 0x01, 0x01 threshold, 0x02 xmax, 0x03 ymax, then pixels to 0x04; pwdatas[31:8]=0.
REQ-014 Each APB transfer: one setup cycle (psels=1, penables=0), then access cycles (psels=1, penables=1) until preadys=1 sampled; next cycle psels=penables=0.
REQ-015 paddrs, pwrites, pwdatas stable from setup through final access cycle.
REQ-016 At least one psels=0 cycle between any two transfers; after pixel writes exactly max(GAP_CYC,1) idle cycles (GAP state).
REQ-017 Access-phase cycle counter; if WAIT_MAX access cycles elapse without preadys: drop psels/penables, set err, go IDLE, flush FIFO, no frame_done.
REQ-018 FIFO: pix_ready = not full; accepts pixels only while busy; pix_ready=0 in IDLE.
REQ-019 PIX issues a write only when FIFO non-empty; entry popped on completing write; simultaneous push and pop allowed on full or empty FIFO without loss.
REQ-020 Pixel counter 9 bits; after cfg_xmax (256 if 0) completed pixel writes, go to RDSUM (macro on) or DONE.
REQ-021 DONE: frame_done=1 for one cycle, then IDLE; err cleared by next accepted start.
REQ-022 start while busy is ignored; FIFO pixels beyond frame count remain stalled (pix_ready deasserts when full) and are flushed on return to IDLE.

Reset
REQ-023 presetn=0 asynchronously: state IDLE, FIFO empty, counters 0.
REQ-024 Output reset values: psels=penables=pwrites=0, paddrs=pwdatas=0, pix_ready=0, busy=0, frame_done=0, err=0, sum_out=0, sum_valid=0.
REQ-025 Reset mid-transfer aborts it immediately; no completion or error recorded.

Configuration
REQ-026 Macro SUN_FEEDER_READBACK_EN defined: RDSUM performs read of addr 0x06 (pwrites=0); read completes on preadys=1 OR after 2 access cycles without timeout error (slave never asserts preadys on reads); prdatas sampled that cycle into sum_out, sum_valid=1 from next cycle until next start, then DONE.
REQ-027 Macro undefined: no RDSUM state, no read transfers; sum_out and sum_valid tied 0.

Verification
REQ-028 start, threshold=0x10, xmax=3, ymax=1, slave preadys 1 cycle after penables -> writes 0x00=01, 0x01=10, 0x02=03, 0x03=01, three pixel writes to 0x04, frame_done one pulse.
REQ-029 Pixel stream 0x05,0x20,0x30, slave returns prdatas=0x00000050 (macro on) -> sum_out=0x50, sum_valid=1 before frame_done.
REQ-030 Slave never asserts preadys on write 0x01 -> err=1 after 15 access cycles, busy=0, psels=0, no frame_done.
REQ-031 Push 10 pixels with slave stalled -> pix_ready=0 after 8 accepted; all 8 written in order once slave responds; GAP of 4 idle cycles between pixel writes.
REQ-032 presetn low during pixel access phase -> all outputs at reset values same cycle; subsequent start runs full frame cleanly.

Source files
------------

// File: rtl/sun_feeder.sv
// APB frame feeder: writes a config header, streams FIFO-buffered pixels to the slave.
// Optional sum read-back after the pixels is enabled by defining SUN_FEEDER_READBACK_EN.
module sun_feeder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYC    = 4,
    parameter int unsigned WAIT_MAX   = 15
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        start,
    input  logic [7:0]  cfg_threshold,
    input  logic [7:0]  cfg_xmax,
    input  logic [7:0]  cfg_ymax,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        psels,
    output logic        penables,
    output logic        pwrites,
    output logic [31:0] paddrs,
    output logic [31:0] pwdatas,
    input  logic [31:0] prdatas,
    input  logic        preadys,
    output logic        busy,
    output logic        frame_done,
    output logic        err,
    output logic [31:0] sum_out,
    output logic        sum_valid
);

    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned GAP_N = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int unsigned GW    = $clog2(GAP_N + 1);
    localparam int unsigned WW    = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CTRL, S_THR, S_XMAX, S_YMAX, S_PIX, S_GAP,
`ifdef SUN_FEEDER_READBACK_EN
        S_RDSUM,
`endif
        S_DONE
    } state_t;

    // Bus phase within a transfer state; P_WAIT is the mandatory idle slot.
    typedef enum logic [1:0] {P_WAIT, P_SETUP, P_ACCESS} phase_t;

    state_t         state, state_nxt;
    phase_t         phase, phase_nxt;
    logic [WW-1:0]  wait_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [8:0]     pix_cnt;
    logic [8:0]     target;
    logic [7:0]     thr_q, xmax_q, ymax_q;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           fifo_empty, fifo_full, push, pop, flush;
    logic           start_acc, xfer_done, rd_force, timeout;
    logic [31:0]    setup_addr, setup_data;
    logic           setup_wr;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr - rd_ptr) == PW'(FIFO_DEPTH));
    assign pix_ready  = (state != S_IDLE) && !fifo_full;
    assign push       = pix_valid && pix_ready;
    assign pop        = (state == S_PIX) && xfer_done;
    assign flush      = (state_nxt == S_IDLE);
    assign start_acc  = (state == S_IDLE) && start;
    assign target     = {xmax_q == 8'd0, xmax_q};

`ifdef SUN_FEEDER_READBACK_EN
    // The slave never answers reads; they complete on the second access cycle.
    assign rd_force = (state == S_RDSUM) && (wait_cnt == WW'(1));
`else
    assign rd_force = 1'b0;
`endif
    assign xfer_done = (phase == P_ACCESS) && (preadys || rd_force);
    assign timeout   = (phase == P_ACCESS) && !xfer_done && (wait_cnt == WW'(WAIT_MAX - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= S_IDLE;
            phase <= P_WAIT;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        setup_addr = 32'h0;
        setup_data = 32'h0;
        setup_wr   = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CTRL;
                    phase_nxt = P_SETUP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP_N - 1)) begin
                    if (pix_cnt == target) begin
`ifdef SUN_FEEDER_READBACK_EN
                        state_nxt = S_RDSUM;
                        phase_nxt = P_SETUP;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_PIX;
                        phase_nxt = fifo_empty ? P_WAIT : P_SETUP;
                    end
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: begin
                case (phase)
                    P_WAIT:  if (state != S_PIX || !fifo_empty) phase_nxt = P_SETUP;
                    P_SETUP: phase_nxt = P_ACCESS;
                    P_ACCESS: begin
                        if (timeout) begin
                            state_nxt = S_IDLE;
                            phase_nxt = P_WAIT;
                        end else if (xfer_done) begin
                            phase_nxt = P_WAIT;
                            case (state)
                                S_CTRL:  state_nxt = S_THR;
                                S_THR:   state_nxt = S_XMAX;
                                S_XMAX:  state_nxt = S_YMAX;
                                S_YMAX:  state_nxt = S_PIX;
                                S_PIX:   state_nxt = S_GAP;
                                default: state_nxt = S_DONE;
                            endcase
                        end
                    end
                    default: phase_nxt = P_WAIT;
                endcase
            end
        endcase
        // Address/data presented when the next cycle is a setup cycle.
        case (state_nxt)
            S_CTRL: begin setup_addr = 32'h0; setup_data = 32'h1; end
            S_THR:  begin setup_addr = 32'h1; setup_data = 32'(thr_q); end
            S_XMAX: begin setup_addr = 32'h2; setup_data = 32'(xmax_q); end
            S_YMAX: begin setup_addr = 32'h3; setup_data = 32'(ymax_q); end
            S_PIX:  begin setup_addr = 32'h4; setup_data = 32'(mem[rd_ptr[AW-1:0]]); end
`ifdef SUN_FEEDER_READBACK_EN
            S_RDSUM: begin setup_addr = 32'h6; setup_wr = 1'b0; end
`endif
            default: ;
        endcase
    end

    // Counters, captured configuration and registered bus/status outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            pix_cnt    <= '0;
            thr_q      <= '0;
            xmax_q     <= '0;
            ymax_q     <= '0;
            psels      <= 1'b0;
            penables   <= 1'b0;
            pwrites    <= 1'b0;
            paddrs     <= '0;
            pwdatas    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            wait_cnt <= (phase == P_ACCESS && phase_nxt == P_ACCESS) ? wait_cnt + WW'(1) : '0;
            gap_cnt  <= (state == S_GAP && state_nxt == S_GAP) ? gap_cnt + GW'(1) : '0;
            if (start_acc) begin
                thr_q   <= cfg_threshold;
                xmax_q  <= cfg_xmax;
                ymax_q  <= cfg_ymax;
                pix_cnt <= '0;
            end else if (pop) begin
                pix_cnt <= pix_cnt + 9'd1;
            end
            psels    <= (phase_nxt != P_WAIT);
            penables <= (phase_nxt == P_ACCESS);
            if (phase_nxt == P_SETUP) begin
                paddrs  <= setup_addr;
                pwdatas <= setup_data;
                pwrites <= setup_wr;
            end
            busy       <= (state_nxt != S_IDLE);
            frame_done <= (state_nxt == S_DONE);
            if (start_acc)    err <= 1'b0;
            else if (timeout) err <= 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= pix_data;
    end

`ifdef SUN_FEEDER_READBACK_EN
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else if (start_acc) begin
            sum_valid <= 1'b0;
        end else if (state == S_RDSUM && xfer_done) begin
            sum_out   <= prdatas;
            sum_valid <= 1'b1;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^prdatas;
    assign sum_out      = '0;
    assign sum_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_sun_feeder.sv
// Bench for sun_feeder: APB slave model, pixel source and transaction monitor.
module tb_sun_feeder;

    localparam int GAP  = 4;
    localparam int WMAX = 15;
`ifdef SUN_FEEDER_READBACK_EN
    localparam int RD = 1;
`else
    localparam int RD = 0;
`endif

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_threshold = '0, cfg_xmax = '0, cfg_ymax = '0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_ready;
    logic        psels, penables, pwrites;
    logic [31:0] paddrs, pwdatas, prdatas;
    logic        preadys = 1'b0;
    logic        busy, frame_done, err, sum_valid;
    logic [31:0] sum_out;

    int checks = 0, errors = 0;

    logic [7:0]  src_q[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  cfg_exp [4];
    int          n_exp = 0, xfer_idx = 0, fd_cnt = 0, abort_acc = 0;
    int          gap = 0, acc_cnt = 0;
    bit          seen_xfer = 0, last_pix = 0, in_xfer = 0;
    logic [31:0] s_addr, s_data;
    logic        s_wr;
    logic [31:0] rd_value = '0;
    logic [31:0] stall_addr = '1;
    bit          lat_rand = 0;
    int          lat_fix = 1, sl_cnt = 0, sl_lat = 0;

    assign prdatas = rd_value;

    sun_feeder dut (
        .pclk(pclk), .presetn(presetn), .start(start),
        .cfg_threshold(cfg_threshold), .cfg_xmax(cfg_xmax), .cfg_ymax(cfg_ymax),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .psels(psels), .penables(penables), .pwrites(pwrites),
        .paddrs(paddrs), .pwdatas(pwdatas), .prdatas(prdatas), .preadys(preadys),
        .busy(busy), .frame_done(frame_done), .err(err),
        .sum_out(sum_out), .sum_valid(sum_valid)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({psels, penables, pwrites, paddrs, pwdatas, pix_ready,
                     busy, frame_done, err, sum_out, sum_valid});
    endfunction

    // Slave answers writes a chosen number of access cycles late; reads are never acknowledged.
    always @(posedge pclk) begin
        #1;
        preadys = psels && penables && pwrites && (paddrs != stall_addr) && (sl_cnt >= sl_lat);
        if (psels && penables) sl_cnt++;
        else begin
            sl_cnt = 0;
            sl_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
        end
    end

    // Pixel source: presents the queue head, records every handshake.
    always @(posedge pclk) begin
        #1;
        if (src_q.size() > 0) begin
            pix_valid = 1'b1;
            pix_data  = src_q[0];
        end else begin
            pix_valid = 1'b0;
        end
    end

    always @(negedge pclk) begin
        if (presetn && pix_valid && pix_ready && src_q.size() > 0) begin
            acc_q.push_back(pix_data);
            void'(src_q.pop_front());
        end
    end

    // Transfer monitor: spacing, stability and expected write sequence.
    always @(negedge pclk) begin
        if (!presetn) begin
            seen_xfer = 0; in_xfer = 0; gap = 0;
        end else begin
            if (frame_done) fd_cnt++;
            if (psels && !penables) begin
                if (seen_xfer) chk("gap_min", 128'(gap >= 1), 128'(1));
                if (seen_xfer && last_pix) chk("pix_gap", 128'(gap), 128'(GAP));
                s_addr = paddrs; s_data = pwdatas; s_wr = pwrites;
                acc_cnt = 0; gap = 0; in_xfer = 1;
            end else if (psels && penables) begin
                acc_cnt++;
                chk("stable", 128'({paddrs, pwdatas, pwrites}), 128'({s_addr, s_data, s_wr}));
                if (preadys || (!pwrites && acc_cnt == 2)) begin
                    if (xfer_idx < 4) begin
                        chk("cfg_write", 128'({paddrs, pwdatas, pwrites}),
                            128'({32'(xfer_idx), 32'(cfg_exp[xfer_idx]), 1'b1}));
                    end else if (xfer_idx < 4 + n_exp) begin
                        logic [31:0] ed;
                        ed = (xfer_idx - 4 < acc_q.size()) ? 32'(acc_q[xfer_idx - 4]) : 32'hFFFF_FFFF;
                        chk("pix_write", 128'({paddrs, pwdatas, pwrites}), 128'({32'h4, ed, 1'b1}));
                    end else if (RD == 1 && xfer_idx == 4 + n_exp) begin
                        chk("sum_read", 128'({paddrs, pwrites}), 128'({32'h6, 1'b0}));
                    end else begin
                        chk("extra_xfer", 128'(xfer_idx), 128'(4 + n_exp + RD));
                    end
                    seen_xfer = 1;
                    last_pix  = (paddrs == 32'h4);
                    in_xfer   = 0;
                    xfer_idx++;
                end
            end else begin
                if (in_xfer) begin
                    abort_acc = acc_cnt;
                    in_xfer   = 0;
                end
                gap++;
            end
        end
    end

    task automatic set_frame(input logic [7:0] thr, input logic [7:0] xmax, input logic [7:0] ymax);
        cfg_threshold = thr; cfg_xmax = xmax; cfg_ymax = ymax;
        cfg_exp[0] = 8'h01; cfg_exp[1] = thr; cfg_exp[2] = xmax; cfg_exp[3] = ymax;
        n_exp = (xmax == 8'd0) ? 256 : int'(xmax);
        xfer_idx = 0; seen_xfer = 0; last_pix = 0;
        acc_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge pclk); #1 start = 1'b1;
        @(posedge pclk); #1 start = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] thr, input logic [7:0] xmax, input logic [7:0] ymax,
                             input int extra, input bit rnd, input int lat,
                             input logic [31:0] rdv, input bit fill_chk);
        int fd0;
        bit seen;
        set_frame(thr, xmax, ymax);
        if (src_q.size() == 0)
            for (int i = 0; i < n_exp + extra; i++) src_q.push_back(8'($urandom));
        lat_rand = rnd; lat_fix = lat; rd_value = rdv;
        fd0 = fd_cnt;
        pulse_start();
        chk("start_err_clr", 128'({err, busy}), 128'({1'b0, 1'b1}));
        if (fill_chk) begin
            for (int c = 0; c < 40 && acc_q.size() < 8; c++) begin @(negedge pclk); #1; end
            @(negedge pclk); #1;
            chk("fifo_full_ready", 128'(pix_ready), 128'(0));
            chk("fifo_accepted", 128'(acc_q.size()), 128'(8));
        end
        seen = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge pclk);
            if (frame_done) begin seen = 1; break; end
        end
        chk("frame_done_seen", 128'(seen), 128'(1));
        if (RD == 1) chk("sum_result", 128'({sum_valid, sum_out}), 128'({1'b1, rdv}));
        @(negedge pclk);
        chk("done_pulse_idle", 128'({frame_done, busy, err}), 128'(0));
        chk("xfer_count", 128'(xfer_idx), 128'(4 + n_exp + RD));
        chk("frame_count", 128'(fd_cnt - fd0), 128'(1));
        src_q.delete();
    endtask

    initial begin
        int fd0;
        bit hit;
        #1 presetn = 1'b0;
        #12;
        chk("reset_outputs", outs(), 128'(0));
        @(negedge pclk) presetn = 1'b1;
        repeat (2) @(negedge pclk);
        chk("idle_outputs", outs(), 128'(0));

        // Basic three-pixel frame with one-cycle slave latency.
        src_q.push_back(8'h05); src_q.push_back(8'h20); src_q.push_back(8'h30);
        run_frame(8'h10, 8'd3, 8'd1, 0, 0, 1, 32'h0000_0050, 0);

        // Slave stalls the threshold write: timeout path.
        set_frame(8'h44, 8'd4, 8'd2);
        lat_rand = 0; lat_fix = 1; stall_addr = 32'h1;
        for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom));
        fd0 = fd_cnt;
        pulse_start();
        hit = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge pclk);
            if (err) begin hit = 1; break; end
        end
        chk("timeout_err", 128'(hit), 128'(1));
        chk("timeout_bus", 128'({busy, psels, penables}), 128'(0));
        @(negedge pclk);
        chk("timeout_access_cycles", 128'(abort_acc), 128'(WMAX));
        chk("timeout_no_done", 128'(fd_cnt - fd0), 128'(0));
        chk("timeout_sticky", 128'({err, pix_ready}), 128'({1'b1, 1'b0}));
        stall_addr = '1;
        src_q.delete();

        // Ten pixels offered, FIFO of eight fills during the header writes.
        for (int i = 0; i < 10; i++) src_q.push_back(8'($urandom));
        run_frame(8'h80, 8'd8, 8'd3, 0, 0, 1, 32'h1234_5678, 1);

        // Reset during a pixel access phase.
        set_frame(8'h22, 8'd5, 8'd2);
        lat_rand = 0; lat_fix = 3;
        for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
        pulse_start();
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge pclk);
            if (psels && penables && paddrs == 32'h4) begin hit = 1; break; end
        end
        chk("reach_pix_access", 128'(hit), 128'(1));
        #2 presetn = 1'b0;
        #1 chk("reset_async", outs(), 128'(0));
        src_q.delete();
        repeat (2) @(posedge pclk);
        @(negedge pclk) presetn = 1'b1;
        run_frame(8'h33, 8'd4, 8'd7, 2, 1, 0, 32'hCAFE_0001, 0);

        // Boundaries: single pixel, and xmax=0 meaning 256 pixels.
        run_frame(8'h00, 8'd1, 8'd0, 0, 0, 2, 32'h0000_0001, 0);
        run_frame(8'h7F, 8'd0, 8'd9, 0, 0, 0, 32'hFFFF_FFFF, 0);

        for (int f = 0; f < 4; f++)
            run_frame(8'($urandom), 8'($urandom_range(1, 12)), 8'($urandom),
                      int'($urandom_range(0, 3)), 1, 0, $urandom, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
